aes_key_expand: RTL and testbench

- Iterative AES-128 key schedule. Takes one 128-bit cipher key and produces the 11 round keys consumed by the aes_128 pipelined encryption core.
- Computes one round key per clock using four aes_sbox instances.
- Holds all 11 keys stable in registers until a new key is accepted.
- Sits directly upstream of aes_128 and drives its aes_key_i bus.

---
 rtl/aes_key_expand.sv | 214 +++++++++++++++++++++
 tb/tb_aes_key_expand.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_expand.sv
// AES-128 key schedule.
// Holds the 11 round keys in registers and builds one new round key per
// clock after a cipher key is accepted. The next-round word function uses
// four aes_sbox instances (one per byte of the rotated last word). The
// round keys stay stable and flagged valid until the next key is accepted.

// AES forward S-box: multiplicative inverse in GF(2^8) followed by the affine map.
module aes_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] prod;
        logic [7:0] acc;
        prod = 8'h00;
        acc  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                prod = prod ^ acc;
            end else begin
                prod = prod;
            end
            acc = {acc[6:0], 1'b0} ^ (acc[7] ? 8'h1b : 8'h00);
        end
        return prod;
    endfunction

    // Inverse as x^254 = x^2 * x^4 * ... * x^128; maps 0 to 0 as AES requires
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] p2, p4, p8, p16, p32, p64, p128;
        p2   = gf_mul(x, x);
        p4   = gf_mul(p2, p2);
        p8   = gf_mul(p4, p4);
        p16  = gf_mul(p8, p8);
        p32  = gf_mul(p16, p16);
        p64  = gf_mul(p32, p32);
        p128 = gf_mul(p64, p64);
        return gf_mul(gf_mul(gf_mul(p2, p4), gf_mul(p8, p16)),
                      gf_mul(gf_mul(p32, p64), p128));
    endfunction

    // Affine transform: b[i] ^ b[i+4] ^ b[i+5] ^ b[i+6] ^ b[i+7] ^ c[i], c = 0x63
    function automatic logic [7:0] affine(input logic [7:0] b);
        logic [7:0] c;
        logic [7:0] r;
        c = 8'h63;
        r = 8'h00;
        for (int i = 0; i < 8; i++) begin
            r[i] = b[i] ^ b[(i + 4) % 8] ^ b[(i + 5) % 8] ^ b[(i + 6) % 8]
                 ^ b[(i + 7) % 8] ^ c[i];
        end
        return r;
    endfunction

    // Pure combinational substitution
    always_comb begin
        out_byte = affine(gf_inv(in_byte));
    end

endmodule

module aes_key_expand (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  key_vld_i,
    input  logic [127:0]          key_i,
    output logic                  key_rdy_o,
    output logic [10:0][127:0]    round_key_o,
    output logic                  round_key_vld_o,
    output logic                  key_done_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_next_s;
    logic [3:0]         cnt_r;
    logic [7:0]         rcon_r;
    logic [10:0][127:0] rk_r;
    logic               rk_vld_r;
    logic               done_r;
    logic               rdy_r;

    logic [3:0]         prev_idx_s;
    logic [127:0]       prev_rk_s;
    logic [31:0]        rot_s;
    logic [31:0]        sub_s;
    logic [31:0]        temp_s;
    logic [31:0]        nw0_s;
    logic [31:0]        nw1_s;
    logic [31:0]        nw2_s;
    logic [31:0]        nw3_s;
    logic [127:0]       next_rk_s;
    logic [7:0]         rcon_next_s;

    // Select the previous round key; the counter is only 1..10 while expanding
    always_comb begin
        prev_idx_s = 4'd0;
        if ((cnt_r >= 4'd1) && (cnt_r <= 4'd11)) begin
            prev_idx_s = cnt_r - 4'd1;
        end else begin
            prev_idx_s = 4'd0;
        end
        prev_rk_s = rk_r[prev_idx_s];
    end

    // RotWord of the previous last word feeds the four S-boxes
    always_comb begin
        rot_s = {prev_rk_s[23:0], prev_rk_s[31:24]};
    end

    aes_sbox u_sbox0 (.in_byte(rot_s[31:24]), .out_byte(sub_s[31:24]));
    aes_sbox u_sbox1 (.in_byte(rot_s[23:16]), .out_byte(sub_s[23:16]));
    aes_sbox u_sbox2 (.in_byte(rot_s[15:8]),  .out_byte(sub_s[15:8]));
    aes_sbox u_sbox3 (.in_byte(rot_s[7:0]),   .out_byte(sub_s[7:0]));

    // Chain the four words of the next round key and advance rcon by xtime
    always_comb begin
        temp_s      = sub_s ^ {rcon_r, 24'h000000};
        nw0_s       = prev_rk_s[127:96] ^ temp_s;
        nw1_s       = nw0_s ^ prev_rk_s[95:64];
        nw2_s       = nw1_s ^ prev_rk_s[63:32];
        nw3_s       = nw2_s ^ prev_rk_s[31:0];
        next_rk_s   = {nw0_s, nw1_s, nw2_s, nw3_s};
        rcon_next_s = {rcon_r[6:0], 1'b0} ^ (rcon_r[7] ? 8'h1b : 8'h00);
    end

    // Next-state logic: accept in IDLE, ten EXPAND cycles, one DONE cycle
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (key_vld_i) begin
                    state_next_s = EXPAND;
                end else begin
                    state_next_s = IDLE;
                end
            end
            EXPAND: begin
                if (cnt_r == 4'd10) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = EXPAND;
                end
            end
            DONE: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State register; ready and done are registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            rdy_r   <= 1'b1;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            rdy_r   <= (state_next_s == IDLE);
            done_r  <= (state_next_s == DONE);
        end
    end

    // Round-key storage, counter, rcon and the valid level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rk_r     <= '0;
            cnt_r    <= 4'd0;
            rcon_r   <= 8'h01;
            rk_vld_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (key_vld_i) begin
                        rk_r[0]  <= key_i;
                        cnt_r    <= 4'd1;
                        rcon_r   <= 8'h01;
                        rk_vld_r <= 1'b0;
                    end
                end
                EXPAND: begin
                    rk_r[cnt_r] <= next_rk_s;
                    rcon_r      <= rcon_next_s;
                    cnt_r       <= cnt_r + 4'd1;
                end
                DONE: begin
                    rk_vld_r <= 1'b1;
                end
                default: begin
                    rk_vld_r <= 1'b0;
                end
            endcase
        end
    end

    // Outputs come straight from registers
    always_comb begin
        key_rdy_o       = rdy_r;
        key_done_o      = done_r;
        round_key_vld_o = rk_vld_r;
        round_key_o     = rk_r;
    end

endmodule

// File: tb/tb_aes_key_expand.sv
// Scoreboard bench for aes_key_expand: stimulus pushes expected round keys,
// a monitor pops and compares whenever key_done_o pulses.
module tb_aes_key_expand;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               key_vld_i;
    logic [127:0]       key_i;
    logic               key_rdy_o;
    logic [10:0][127:0] round_key_o;
    logic               round_key_vld_o;
    logic               key_done_o;

    aes_key_expand dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .key_vld_i       (key_vld_i),
        .key_i           (key_i),
        .key_rdy_o       (key_rdy_o),
        .round_key_o     (round_key_o),
        .round_key_vld_o (round_key_vld_o),
        .key_done_o      (key_done_o)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_RK1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
    localparam logic [127:0] PT        = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT        = 128'h3925841d02dc09fbdc118597196a0b32;

    typedef struct {
        logic [127:0] rk0;
        logic [127:0] rk1;
        logic [127:0] rk10;
        int           done_cyc;
    } exp_t;

    exp_t sb_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    // Cycle counter, stepped at every active edge
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference AES encryption (for the end-to-end check) ----
    function automatic logic [7:0] tb_xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] tb_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = tb_xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] tb_sbox(input logic [7:0] x);
        logic [7:0] v = 8'h00;
        for (int y = 1; y < 256; y++) begin
            if (tb_mul(x, 8'(y)) == 8'h01) v = 8'(y);
        end
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]}
                 ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] tb_encrypt(input logic [127:0] pt,
                                                input logic [10:0][127:0] rks);
        logic [7:0]   s[16];
        logic [7:0]   t[16];
        logic [127:0] out;
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rks[0][127-8*i -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = tb_sbox(s[i]);
            for (int c = 0; c < 4; c++)
                for (int w = 0; w < 4; w++) s[c*4+w] = t[((c + w) % 4)*4 + w];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    logic [7:0] a0, a1, a2, a3;
                    a0 = s[c*4]; a1 = s[c*4+1]; a2 = s[c*4+2]; a3 = s[c*4+3];
                    s[c*4]   = tb_xt(a0) ^ tb_xt(a1) ^ a1 ^ a2 ^ a3;
                    s[c*4+1] = a0 ^ tb_xt(a1) ^ tb_xt(a2) ^ a2 ^ a3;
                    s[c*4+2] = a0 ^ a1 ^ tb_xt(a2) ^ tb_xt(a3) ^ a3;
                    s[c*4+3] = tb_xt(a0) ^ a0 ^ a1 ^ a2 ^ tb_xt(a3);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ rks[r][127-8*i -: 8];
        end
        for (int i = 0; i < 16; i++) out[127-8*i -: 8] = s[i];
        return out;
    endfunction

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        bit   chk_next = 1'b0;
        forever begin
            @(negedge clk);
            if (chk_next) begin
                check("vld_after_done", {127'd0, round_key_vld_o}, 128'd1);
                check("done_one_cycle", {127'd0, key_done_o}, 128'd0);
                chk_next = 1'b0;
            end
            if (rst_n && key_done_o) begin
                if (sb_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done: got done pulse expected none (cycle %0d)", cyc);
                end else begin
                    e = sb_q.pop_front();
                    check("rk0", round_key_o[0], e.rk0);
                    check("rk1", round_key_o[1], e.rk1);
                    check("rk10", round_key_o[10], e.rk10);
                    check("done_cycle", 128'(cyc), 128'(e.done_cyc));
                    check("vld_during_done", {127'd0, round_key_vld_o}, 128'd0);
                    check("rdy_during_done", {127'd0, key_rdy_o}, 128'd0);
                end
                chk_next = 1'b1;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic load_key(input logic [127:0] k, input logic [127:0] e1,
                            input logic [127:0] e10, input bit push, output int acc);
        int n = 0;
        while (!key_rdy_o && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("rdy_before_load", {127'd0, key_rdy_o}, 128'd1);
        key_i     = k;
        key_vld_i = 1'b1;
        @(posedge clk);
        #1;
        acc       = cyc;
        key_vld_i = 1'b0;
        key_i     = 128'h0123456789abcdeffedcba9876543210;
        if (push) sb_q.push_back('{k, e1, e10, acc + 10});
    endtask

    task automatic wait_vld();
        int n = 0;
        while (!round_key_vld_o && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("vld_wait", {127'd0, round_key_vld_o}, 128'd1);
        @(negedge clk);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_vld"},  {127'd0, round_key_vld_o}, 128'd0);
        check({tag, "_done"}, {127'd0, key_done_o}, 128'd0);
        check({tag, "_rdy"},  {127'd0, key_rdy_o}, 128'd1);
        check({tag, "_rk_or"}, {127'd0, |round_key_o}, 128'd0);
    endtask

    initial begin
        int acc;
        rst_n     = 1'b0;
        key_vld_i = 1'b0;
        key_i     = 128'd0;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // FIPS-197 key with busy pulses of all-ones at EXPAND cycles 3 and 10
        load_key(FIPS_KEY, FIPS_RK1, FIPS_RK10, 1'b1, acc);
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            check("rdy_busy", {127'd0, key_rdy_o}, 128'd0);
            if (c == 3 || c == 10) begin
                key_vld_i = 1'b1;
                key_i     = {128{1'b1}};
            end else begin
                key_vld_i = 1'b0;
            end
        end
        key_vld_i = 1'b0;
        wait_vld();
        check("fips_rk1_stable", round_key_o[1], FIPS_RK1);

        // Rekey with the zero key while keys are valid
        load_key(128'd0, ZERO_RK1, ZERO_RK10, 1'b1, acc);
        check("vld_drop_on_rekey", {127'd0, round_key_vld_o}, 128'd0);
        wait_vld();

        // Reset in the middle of an expansion
        load_key(FIPS_KEY, FIPS_RK1, FIPS_RK10, 1'b0, acc);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_state("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Fresh FIPS load after reset, then end-to-end encryption with the keys
        load_key(FIPS_KEY, FIPS_RK1, FIPS_RK10, 1'b1, acc);
        wait_vld();
        check("aes_ciphertext", tb_encrypt(PT, round_key_o), CT);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 128'(sb_q.size()), 128'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
